data_mem_if: RTL and testbench
==============================

Name: data_mem_if

Overview:
Parametrised load/store interface between the core's M-stage data port and a variable-latency data memory.
Adds what the single-cycle data port lacks: byte/half/word (and dword at 64-bit) sizes, byte enables, lane alignment and sign/zero extension of loads, misalignment detection, and a req/ack handshake with wait states.
Core stalls while an access is outstanding.

Parameters:
DATA_WIDTH, 32, data bus width; legal values 32 or 64.
ADDR_WIDTH, 32, byte address width.
TIMEOUT_CYCLES, 16, maximum ACCESS cycles without ack; used only with the optional feature.

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low (0 = reset)
i_req_valid  input  1  core access request
o_req_ready  output  1  block accepts a request this cycle
i_we  input  1  1 = store, 0 = load
i_size  input  2  00 byte, 01 half, 10 word, 11 dword (legal only when DATA_WIDTH=64)
i_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
i_addr  input  ADDR_WIDTH  byte address
i_wdata  input  DATA_WIDTH  store data, right-aligned
o_rsp_valid  output  1  one-cycle completion pulse
o_rdata  output  DATA_WIDTH  load result, aligned and extended
o_misaligned  output  1  qualifies o_rsp_valid: access rejected
o_bus_err  output  1  qualifies o_rsp_valid: access timed out
o_stall  output  1  core pipeline stall request
o_mem_req  output  1  memory request
o_mem_we  output  1  memory write
o_mem_addr  output  ADDR_WIDTH  address aligned to DATA_WIDTH/8 (low bits zero)
o_mem_be  output  DATA_WIDTH/8  byte enables
o_mem_wdata  output  DATA_WIDTH  lane-replicated store data
i_mem_ack  input  1  memory completes the access
i_mem_rdata  input  DATA_WIDTH  memory read data, valid with ack

Behaviour:
- FSM has three states:
  - IDLE: o_req_ready=1. Request accepted when i_req_valid=1.
  - ACCESS: o_mem_req=1 and o_stall=1.
  - RESP: o_rsp_valid=1 for exactly one cycle, then return to IDLE.
- Reset (rst=0 at an edge): state goes to IDLE and every output register clears, including o_mem_req, o_rsp_valid, o_rdata, o_misaligned and o_bus_err. While rst=0, o_req_ready=0.
- Reset mid-ACCESS: o_mem_req drops at that edge, no response is generated, and a late i_mem_ack is ignored.
- Misalignment is checked at accept:
  - half with addr[0]!=0, word with addr[1:0]!=0, dword with addr[2:0]!=0.
  - size 11 is always illegal when DATA_WIDTH=32.
  - Illegal access: no memory request; go straight to RESP with o_misaligned=1 and o_rdata=0.
- Legal access: latch the request and go to ACCESS on the next edge.
  - o_mem_addr, o_mem_be, o_mem_wdata and o_mem_we stay stable throughout ACCESS.
- Byte enables and store data:
  - o_mem_be = size mask (1, 3, 0xF or 0xFF) shifted left by the byte offset.
  - Store data is replicated across lanes: byte to every byte lane, half to every half lane, word to both word lanes at 64-bit.
- Ack handling:
  - i_mem_ack is sampled in ACCESS; ack in the first ACCESS cycle is legal, giving zero wait states.
  - On ack: load data is shifted right by offset*8, masked to size, extended per i_unsigned to DATA_WIDTH and registered into o_rdata; next state is RESP.
  - Stores return o_rdata=0.
- Latency: accept at edge T, o_mem_req high from T+1, ack at T+1 gives o_rsp_valid in cycle T+2, and o_req_ready returns at T+3. Each wait state adds one cycle.
- i_mem_ack outside ACCESS is ignored.
- o_rdata holds its value until the next completed response.

Optional Feature:
DATA_MEM_TIMEOUT_EN:
- Defined: a counter runs in ACCESS. If TIMEOUT_CYCLES cycles elapse without ack, the block drops o_mem_req, goes to RESP with o_bus_err=1 and o_rdata=0, and a later ack is ignored.
- Undefined: no counter; ACCESS waits indefinitely and o_bus_err is tied 0.

Test Plan:
- Load word, DATA_WIDTH=32, addr 0x100, mem_rdata 0xDEADBEEF, ack on first ACCESS cycle -> be=0xF, mem_addr 0x100, rsp_valid at T+2, rdata 0xDEADBEEF.
- Load byte signed, addr 0x103, rdata 0x80112233 -> be=0x8, rdata 0xFFFFFF80; same access with i_unsigned=1 -> 0x00000080.
- Store half, addr 0x102, wdata 0x0000ABCD -> be=0xC, mem_wdata 0xABCDABCD, rsp_valid with rdata 0.
- Misaligned word, addr 0x101 -> o_mem_req never rises, rsp_valid with o_misaligned=1 at T+1; size 11 at 32-bit -> same response.
- Three wait states, then ack -> o_mem_req and o_stall high for 4 cycles, signals stable; rst=0 asserted during a second access -> o_mem_req low next edge, no rsp_valid.
- With DATA_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> o_mem_req high 4 cycles, rsp_valid with o_bus_err=1.

Source files
------------

// File: rtl/data_mem_if.sv
// Load/store bridge between the core M-stage data port and a variable-latency data memory.
// Optional ACCESS timeout with bus error response: define DATA_MEM_TIMEOUT_EN.
module data_mem_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_we,
    input  logic [1:0]              i_size,
    input  logic                    i_unsigned,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic                    o_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic                    o_misaligned,
    output logic                    o_bus_err,
    output logic                    o_stall,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH/8-1:0] o_mem_be,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    input  logic                    i_mem_ack,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);

    if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("data_mem_if: unsupported parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e                  state_q, state_d;
    logic                    we_q, uns_q, misaligned_q;
    logic [1:0]              size_q;
    logic [OFF_W-1:0]        off_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [BE_W-1:0]         be_q;
    logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;

    logic                    accept, req_mis, timeout_hit, bus_err;
    logic [OFF_W-1:0]        req_off;
    logic [BE_W-1:0]         size_mask;
    logic [DATA_WIDTH-1:0]   req_wdata, shifted, load_mask, load_ext;
    logic                    load_sign;

    assign accept  = (state_q == StIdle) && i_req_valid;
    assign req_off = i_addr[OFF_W-1:0];

    // Request decode: alignment check, lane enables and lane-replicated store data
    always_comb begin
        req_mis   = 1'b0;
        size_mask = '1;
        req_wdata = i_wdata;
        unique case (i_size)
            2'b00: begin
                size_mask = BE_W'(1);
                req_wdata = {BE_W{i_wdata[7:0]}};
            end
            2'b01: begin
                req_mis   = i_addr[0];
                size_mask = BE_W'(3);
                req_wdata = {(BE_W / 2){i_wdata[15:0]}};
            end
            2'b10: begin
                req_mis   = (i_addr[1:0] != 2'b00);
                size_mask = BE_W'(4'hF);
                req_wdata = {(DATA_WIDTH / 32){i_wdata[31:0]}};
            end
            default: begin
                req_mis   = (DATA_WIDTH == 32) ? 1'b1 : (req_off != '0);
                size_mask = '1;
                req_wdata = i_wdata;
            end
        endcase
    end

    // Load path: bring the addressed lane down to bit 0, then mask and extend
    always_comb begin
        shifted   = i_mem_rdata >> {off_q, 3'b000};
        load_mask = '1;
        load_sign = shifted[DATA_WIDTH-1];
        unique case (size_q)
            2'b00: begin
                load_mask = DATA_WIDTH'(8'hFF);
                load_sign = shifted[7];
            end
            2'b01: begin
                load_mask = DATA_WIDTH'(16'hFFFF);
                load_sign = shifted[15];
            end
            2'b10: begin
                load_mask = DATA_WIDTH'(32'hFFFF_FFFF);
                load_sign = shifted[31];
            end
            default: begin
                load_mask = '1;
                load_sign = shifted[DATA_WIDTH-1];
            end
        endcase
        load_ext = (shifted & load_mask) | ((load_sign && !uns_q) ? ~load_mask : '0);
    end

`ifdef DATA_MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_q;
    logic             bus_err_q;

    assign timeout_hit = (state_q == StAccess) && !i_mem_ack &&
                         (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_err     = bus_err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_q <= (state_q == StAccess) ? tmo_q + CNT_W'(1) : '0;
            if (accept) begin
                bus_err_q <= 1'b0;
            end else if (timeout_hit) begin
                bus_err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (i_req_valid) state_d = req_mis ? StResp : StAccess;
            StAccess: if (i_mem_ack || timeout_hit) state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= 2'b00;
            off_q        <= '0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q         <= i_we;
                uns_q        <= i_unsigned;
                size_q       <= i_size;
                off_q        <= req_off;
                addr_q       <= {i_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                be_q         <= size_mask << req_off;
                wdata_q      <= req_wdata;
                misaligned_q <= req_mis;
                if (req_mis) rdata_q <= '0;
            end
            if (state_q == StAccess && i_mem_ack) begin
                rdata_q <= we_q ? '0 : load_ext;
            end else if (timeout_hit) begin
                rdata_q <= '0;
            end
        end
    end

    assign o_req_ready  = rst && (state_q == StIdle);
    assign o_stall      = (state_q == StAccess);
    assign o_mem_req    = (state_q == StAccess);
    assign o_mem_we     = we_q;
    assign o_mem_addr   = addr_q;
    assign o_mem_be     = be_q;
    assign o_mem_wdata  = wdata_q;
    assign o_rsp_valid  = (state_q == StResp);
    assign o_rdata      = rdata_q;
    assign o_misaligned = misaligned_q && (state_q == StResp);
    assign o_bus_err    = bus_err && (state_q == StResp);

endmodule

// File: tb/tb_data_mem_if.sv
// Directed, table-driven bench for data_mem_if at DATA_WIDTH=32.
module tb_data_mem_if;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req_valid = 1'b0, i_we = 1'b0, i_unsigned = 1'b0, i_mem_ack = 1'b0;
    logic [1:0]  i_size = 2'b00;
    logic [31:0] i_addr = '0, i_wdata = '0, i_mem_rdata = '0;
    logic        o_req_ready, o_rsp_valid, o_misaligned, o_bus_err, o_stall;
    logic        o_mem_req, o_mem_we;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_if #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_we        (i_we),
        .i_size      (i_size),
        .i_unsigned  (i_unsigned),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_rsp_valid (o_rsp_valid),
        .o_rdata     (o_rdata),
        .o_misaligned(o_misaligned),
        .o_bus_err   (o_bus_err),
        .o_stall     (o_stall),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_be    (o_mem_be),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem_rdata;
        int          ws;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic        mis;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] mem_rdata, input int ws,
                                input logic [3:0] be, input logic [31:0] maddr,
                                input logic [31:0] mwdata, input logic mis,
                                input logic [31:0] rdata);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.mem_rdata = mem_rdata; v.ws = ws; v.be = be; v.maddr = maddr;
        v.mwdata = mwdata; v.mis = mis; v.rdata = rdata;
        return v;
    endfunction

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        i_req_valid = 1'b1; i_we = we; i_size = size; i_unsigned = uns;
        i_addr = addr; i_wdata = wdata;
        step();
        i_req_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        check({tag, " ready"}, 32'(o_req_ready), 32'd1);
        issue(v.we, v.size, v.uns, v.addr, v.wdata);
        if (!v.mis) begin
            for (int w = 0; w <= v.ws; w++) begin
                check({tag, " mem_req"}, 32'(o_mem_req), 32'd1);
                check({tag, " stall"}, 32'(o_stall), 32'd1);
                check({tag, " rsp_early"}, 32'(o_rsp_valid), 32'd0);
                check({tag, " be"}, 32'(o_mem_be), 32'(v.be));
                check({tag, " mem_addr"}, o_mem_addr, v.maddr);
                check({tag, " mem_wdata"}, o_mem_wdata, v.mwdata);
                check({tag, " mem_we"}, 32'(o_mem_we), 32'(v.we));
                i_mem_ack   = (w == v.ws);
                i_mem_rdata = (w == v.ws) ? v.mem_rdata : 32'h5A5A_0F0F;
                step();
                i_mem_ack = 1'b0;
            end
        end
        check({tag, " rsp_valid"}, 32'(o_rsp_valid), 32'd1);
        check({tag, " misaligned"}, 32'(o_misaligned), 32'(v.mis));
        check({tag, " bus_err"}, 32'(o_bus_err), 32'd0);
        check({tag, " mem_req_rsp"}, 32'(o_mem_req), 32'd0);
        check({tag, " rdata"}, o_rdata, v.rdata);
        step();
        check({tag, " rsp_once"}, 32'(o_rsp_valid), 32'd0);
        check({tag, " ready_back"}, 32'(o_req_ready), 32'd1);
        check({tag, " rdata_hold"}, o_rdata, v.rdata);
    endtask

    initial begin
        int n;
        vecs[0]  = mk(0, 2'b10, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0,
                      4'hF, 32'h100, 32'h0,        0, 32'hDEADBEEF);
        vecs[1]  = mk(0, 2'b00, 0, 32'h103, 32'h0,        32'h80112233, 0,
                      4'h8, 32'h100, 32'h0,        0, 32'hFFFFFF80);
        vecs[2]  = mk(0, 2'b10, 0, 32'h101, 32'h0,        32'h0,        0,
                      4'h0, 32'h0,   32'h0,        1, 32'h0);
        vecs[3]  = mk(0, 2'b00, 1, 32'h103, 32'h0,        32'h80112233, 0,
                      4'h8, 32'h100, 32'h0,        0, 32'h00000080);
        vecs[4]  = mk(1, 2'b01, 0, 32'h102, 32'h0000ABCD, 32'h12345678, 0,
                      4'hC, 32'h100, 32'hABCDABCD, 0, 32'h0);
        vecs[5]  = mk(0, 2'b11, 0, 32'h200, 32'h0,        32'h0,        0,
                      4'h0, 32'h0,   32'h0,        1, 32'h0);
        vecs[6]  = mk(0, 2'b01, 0, 32'h202, 32'h0,        32'h80017FFF, 1,
                      4'hC, 32'h200, 32'h0,        0, 32'hFFFF8001);
        vecs[7]  = mk(0, 2'b01, 1, 32'h200, 32'h0,        32'h1234F00D, 0,
                      4'h3, 32'h200, 32'h0,        0, 32'h0000F00D);
        vecs[8]  = mk(1, 2'b00, 0, 32'h305, 32'h000000A5, 32'hFFFFFFFF, 3,
                      4'h2, 32'h304, 32'hA5A5A5A5, 0, 32'h0);
        vecs[9]  = mk(0, 2'b01, 0, 32'h107, 32'h0,        32'h0,        0,
                      4'h0, 32'h0,   32'h0,        1, 32'h0);
        vecs[10] = mk(0, 2'b00, 0, 32'h000, 32'h0,        32'h0000007F, 0,
                      4'h1, 32'h0,   32'h0,        0, 32'h0000007F);
        vecs[11] = mk(1, 2'b10, 0, 32'h400, 32'hCAFEF00D, 32'h0,        2,
                      4'hF, 32'h400, 32'hCAFEF00D, 0, 32'h0);

        // Reset state
        step();
        step();
        check("rst ready", 32'(o_req_ready), 32'd0);
        check("rst mem_req", 32'(o_mem_req), 32'd0);
        check("rst rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("rst rdata", o_rdata, 32'd0);
        check("rst misaligned", 32'(o_misaligned), 32'd0);
        check("rst bus_err", 32'(o_bus_err), 32'd0);
        rst = 1'b1;
        step();
        check("post rst ready", 32'(o_req_ready), 32'd1);

        // Stray ack while idle must be ignored
        i_mem_ack = 1'b1;
        i_mem_rdata = 32'h11111111;
        step();
        i_mem_ack = 1'b0;
        check("idle ack rsp", 32'(o_rsp_valid), 32'd0);
        check("idle ack mem_req", 32'(o_mem_req), 32'd0);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Reset mid-ACCESS, then a late ack
        issue(1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
        check("mid mem_req", 32'(o_mem_req), 32'd1);
        step();
        check("mid wait mem_req", 32'(o_mem_req), 32'd1);
        rst = 1'b0;
        step();
        check("mid rst mem_req", 32'(o_mem_req), 32'd0);
        check("mid rst rsp", 32'(o_rsp_valid), 32'd0);
        check("mid rst ready", 32'(o_req_ready), 32'd0);
        check("mid rst rdata", o_rdata, 32'd0);
        rst = 1'b1;
        i_mem_ack = 1'b1;
        i_mem_rdata = 32'h22222222;
        step();
        i_mem_ack = 1'b0;
        check("late ack rsp", 32'(o_rsp_valid), 32'd0);
        check("late ack mem_req", 32'(o_mem_req), 32'd0);
        check("late ack ready", 32'(o_req_ready), 32'd1);
        step();
        check("late ack rsp2", 32'(o_rsp_valid), 32'd0);

`ifdef DATA_MEM_TIMEOUT_EN
        // No ack: the request must be abandoned after TIMEOUT_CYCLES
        issue(1'b0, 2'b10, 1'b0, 32'h600, 32'h0);
        n = 0;
        while (o_mem_req && n < 20) begin
            n++;
            step();
        end
        check("tmo cycles", 32'(n), 32'd4);
        check("tmo rsp", 32'(o_rsp_valid), 32'd1);
        check("tmo bus_err", 32'(o_bus_err), 32'd1);
        check("tmo rdata", o_rdata, 32'd0);
        i_mem_ack = 1'b1;
        step();
        i_mem_ack = 1'b0;
        check("tmo late rsp", 32'(o_rsp_valid), 32'd0);
        check("tmo late mem_req", 32'(o_mem_req), 32'd0);
        check("tmo ready", 32'(o_req_ready), 32'd1);
`else
        // Without the timeout, ACCESS holds indefinitely with no bus error
        issue(1'b0, 2'b10, 1'b0, 32'h600, 32'h0);
        n = 0;
        while (o_mem_req && n < 20) begin
            n++;
            step();
        end
        check("no tmo still waiting", 32'(n), 32'd20);
        i_mem_ack = 1'b1;
        i_mem_rdata = 32'h0BADF00D;
        step();
        i_mem_ack = 1'b0;
        check("no tmo rsp", 32'(o_rsp_valid), 32'd1);
        check("no tmo bus_err", 32'(o_bus_err), 32'd0);
        check("no tmo rdata", o_rdata, 32'h0BADF00D);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
